h264_recon_chroma: RTL and testbench

H264_RECON_CHROMA -- requirements
Module: h264_recon_chroma

---
 rtl/h264_recon_chroma.sv | 117 +++++++++++
 tb/tb_h264_recon_chroma.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_recon_chroma.sv
// Chroma reconstruction: prediction base + inverse-transform residual, clipped to 8 bits.
// Optional RECON_ERRCHK_EN enables the sticky ERR flag for dropped bases/rows.
module h264_recon_chroma (
  input  logic        CLK2,
  input  logic        RST_N,
  input  logic        NEWLINE,
  input  logic        BSTROBEI,
  input  logic [31:0] BASEI,
  input  logic        STROBEI,
  input  logic [39:0] DATAI,
  output logic        READYI,
  output logic        STROBEO,
  output logic [31:0] DATAO,
  output logic        FBSTROBE,
  output logic [7:0]  FEEDBO,
  output logic        ERR
);

  logic [2:0]  count_q, count_d;
  logic [1:0]  wptr_q, rptr_q, bcnt_q, rcnt_q;
  logic [31:0] fifo_q [4];
  logic [31:0] base_head;
  logic        s1_vld_q;
  logic [10:0] sum_q [4];
  logic [31:0] clip_d;
  logic        b_acc, r_acc, push_try, push, pop;

  // Only the first base row of each block carries a new prediction base.
  always_comb begin
    b_acc    = BSTROBEI & ~NEWLINE;
    r_acc    = STROBEI & ~NEWLINE & (count_q != 3'd0);
    pop      = r_acc & (rcnt_q == 2'd3);
    push_try = b_acc & (bcnt_q == 2'd0);
    push     = push_try & ((count_q != 3'd4) | pop);
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  assign READYI    = (count_q != 3'd4);
  assign base_head = fifo_q[rptr_q];

  always_ff @(posedge CLK2 or negedge RST_N) begin
    if (!RST_N) begin
      count_q  <= 3'd0;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      bcnt_q   <= 2'd0;
      rcnt_q   <= 2'd0;
      s1_vld_q <= 1'b0;
    end else if (NEWLINE) begin
      count_q  <= 3'd0;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      bcnt_q   <= 2'd0;
      rcnt_q   <= 2'd0;
      s1_vld_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      if (push)  wptr_q <= wptr_q + 2'd1;
      if (pop)   rptr_q <= rptr_q + 2'd1;
      if (b_acc) bcnt_q <= bcnt_q + 2'd1;
      if (r_acc) rcnt_q <= rcnt_q + 2'd1;
      s1_vld_q <= r_acc;
    end
  end

  always_ff @(posedge CLK2) begin
    if (push) fifo_q[wptr_q] <= BASEI;
  end

  always_ff @(posedge CLK2) begin
    if (r_acc) begin
      for (int i = 0; i < 4; i++) begin
        sum_q[i] <= {3'b000, base_head[8*i +: 8]} + {DATAI[10*i+9], DATAI[10*i +: 10]};
      end
    end
  end

  // Bit 10 is the sign; bits 9:8 set on a non-negative sum mean overflow past 255.
  always_comb begin
    clip_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sum_q[i][10])               clip_d[8*i +: 8] = 8'h00;
      else if (sum_q[i][9:8] != 2'b00) clip_d[8*i +: 8] = 8'hFF;
      else                            clip_d[8*i +: 8] = sum_q[i][7:0];
    end
  end

  always_ff @(posedge CLK2 or negedge RST_N) begin
    if (!RST_N) begin
      STROBEO  <= 1'b0;
      FBSTROBE <= 1'b0;
      DATAO    <= 32'h0;
      FEEDBO   <= 8'h0;
    end else begin
      STROBEO  <= s1_vld_q & ~NEWLINE;
      FBSTROBE <= s1_vld_q & ~NEWLINE;
      if (s1_vld_q && !NEWLINE) begin
        DATAO  <= clip_d;
        FEEDBO <= clip_d[31:24];
      end
    end
  end

`ifdef RECON_ERRCHK_EN
  logic push_drop, row_drop;
  assign push_drop = push_try & ~push;
  assign row_drop  = STROBEI & ~NEWLINE & (count_q == 3'd0);

  always_ff @(posedge CLK2 or negedge RST_N) begin
    if (!RST_N)                    ERR <= 1'b0;
    else if (push_drop | row_drop) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_h264_recon_chroma.sv
// Scoreboard bench for h264_recon_chroma: a reference model predicts each
// reconstructed row when the residual is driven; the monitor pops and compares.
module tb_h264_recon_chroma;

  logic        CLK2 = 1'b0;
  logic        RST_N, NEWLINE, BSTROBEI, STROBEI;
  logic [31:0] BASEI;
  logic [39:0] DATAI;
  logic        READYI, STROBEO, FBSTROBE, ERR;
  logic [31:0] DATAO;
  logic [7:0]  FEEDBO;

  h264_recon_chroma dut (
    .CLK2(CLK2), .RST_N(RST_N), .NEWLINE(NEWLINE),
    .BSTROBEI(BSTROBEI), .BASEI(BASEI), .STROBEI(STROBEI), .DATAI(DATAI),
    .READYI(READYI), .STROBEO(STROBEO), .DATAO(DATAO),
    .FBSTROBE(FBSTROBE), .FEEDBO(FEEDBO), .ERR(ERR)
  );

  always #5 CLK2 = ~CLK2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  logic [31:0] mq[$];
  int          m_bcnt = 0;
  int          m_rcnt = 0;
  bit          m_err  = 0;
  logic [31:0] exp_last = 32'h0;

  always @(posedge CLK2) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    return {d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  function automatic logic [31:0] recon(input logic [31:0] base, input logic [39:0] res);
    logic [31:0] o;
    logic [9:0]  rr;
    int          v;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      rr = res[10*i +: 10];
      v  = int'(base[8*i +: 8]) + int'($signed(rr));
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      o[8*i +: 8] = v[7:0];
    end
    return o;
  endfunction

  function automatic bit exp_err();
`ifdef RECON_ERRCHK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_readyi"}, {63'h0, READYI}, {63'h0, (mq.size() != 4)});
    chk({tag, "_err"}, {63'h0, ERR}, {63'h0, exp_err()});
  endtask

  // One clock of stimulus; entered and left 1ns after a rising edge.
  task automatic step(input bit b, input logic [31:0] base, input bit s,
                      input logic [39:0] res, input bit nl);
    bit   pop, push_new;
    exp_t e;
    BSTROBEI = b; BASEI = base; STROBEI = s; DATAI = res; NEWLINE = nl;
    pop = 0; push_new = 0;
    if (nl) begin
      mq.delete();
      m_bcnt = 0;
      m_rcnt = 0;
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end else begin
      if (s) begin
        if (mq.size() != 0) begin
          e.data = recon(mq[0], res);
          e.due  = cyc + 2;
          sb.push_back(e);
          pop    = (m_rcnt == 3);
          m_rcnt = (m_rcnt + 1) % 4;
        end else begin
          m_err = 1;
        end
      end
      if (b) begin
        if (m_bcnt == 0) begin
          if (mq.size() != 4 || pop) push_new = 1;
          else                       m_err = 1;
        end
        m_bcnt = (m_bcnt + 1) % 4;
      end
      if (pop)      void'(mq.pop_front());
      if (push_new) mq.push_back(base);
    end
    @(posedge CLK2);
    #1;
    BSTROBEI = 0; STROBEI = 0; NEWLINE = 0;
  endtask

  task automatic bases(input logic [31:0] base);
    step(1, base, 0, '0, 0);
    for (int i = 1; i < 4; i++) step(1, ~base ^ i, 0, '0, 0);
  endtask

  task automatic rows(input logic [39:0] res, input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1, res, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobeo"},  {63'h0, STROBEO},  64'h0);
    chk({tag, "_fbstrobe"}, {63'h0, FBSTROBE}, 64'h0);
    chk({tag, "_datao"},    {32'h0, DATAO},    64'h0);
    chk({tag, "_feedbo"},   {56'h0, FEEDBO},   64'h0);
    chk({tag, "_err"},      {63'h0, ERR},      64'h0);
    chk({tag, "_readyi"},   {63'h0, READYI},   64'h1);
  endtask

  // Asserts reset between clock edges, then releases it 1ns after an edge.
  task automatic async_reset();
    #2;
    RST_N = 1'b0;
    mq.delete(); sb.delete();
    m_bcnt = 0; m_rcnt = 0; m_err = 0; exp_last = 32'h0;
    #1;
    chk_reset_outputs("rst_async");
    repeat (2) @(posedge CLK2);
    #1;
    RST_N = 1'b1;
  endtask

  always @(negedge CLK2) begin
    exp_t e;
    if (RST_N === 1'b1) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("strobeo",  {63'h0, STROBEO},  64'h1);
        chk("fbstrobe", {63'h0, FBSTROBE}, 64'h1);
        chk("datao",    {32'h0, DATAO},    {32'h0, e.data});
        chk("feedbo",   {56'h0, FEEDBO},   {56'h0, e.data[31:24]});
        exp_last = e.data;
      end else begin
        chk("strobeo_idle", {63'h0, STROBEO}, 64'h0);
        chk("datao_hold",   {32'h0, DATAO},   {32'h0, exp_last});
        chk("feedbo_hold",  {56'h0, FEEDBO},  {56'h0, exp_last[31:24]});
      end
    end
  end

  initial begin
    RST_N = 1'b0; NEWLINE = 0; BSTROBEI = 0; STROBEI = 0; BASEI = '0; DATAI = '0;
    #1;
    chk_reset_outputs("rst_init");
    repeat (2) @(posedge CLK2);
    #1;
    RST_N = 1'b1;
    idle(2);
    chk_state("post_reset");

    // mid-grey base with mixed residuals
    bases(32'h80808080);
    rows(pk(5, -3, 0, 127), 4);
    idle(3);
    chk_state("blk_grey");

    // clipping at both ends
    bases(32'h05FA0A10);
    rows(pk(-20, 10, -10, 300), 4);
    idle(3);
    chk_state("blk_clip");

    // overfill: fifth base dropped, FIFO order preserved on drain
    bases(32'h11223344);
    bases(32'h55667788);
    bases(32'h99AABBCC);
    bases(32'hDDEEFF00);
    chk_state("full4");
    bases(32'h01020304);
    chk_state("drop5");
    rows(pk(1, 2, 3, 4), 16);
    idle(3);
    chk_state("drain5");

    // full FIFO: push coincides with final-row pop
    bases(32'h10101010);
    bases(32'h20202020);
    bases(32'h30303030);
    bases(32'h40404040);
    rows(pk(-1, 1, -2, 2), 3);
    step(1, 32'h50505050, 1, pk(-1, 1, -2, 2), 0);
    chk_state("pushpop");
    for (int i = 1; i < 4; i++) step(1, 32'hFFFFFFFF, 0, '0, 0);
    rows(pk(7, -7, 100, -100), 16);
    idle(3);
    chk_state("pushpop_drain");

    // empty-FIFO row, then flush mid-block
    rows(pk(9, 9, 9, 9), 1);
    idle(3);
    chk_state("empty_row");
    bases(32'hC0C0C0C0);
    bases(32'h3F3F3F3F);
    rows(pk(3, 3, 3, 3), 2);
    idle(3);
    step(0, '0, 1, pk(4, 4, 4, 4), 1);
    idle(3);
    chk_state("newline");
    bases(32'h01010101);
    bases(32'hFEFEFEFE);
    rows(pk(-5, 5, 200, -200), 8);
    idle(3);
    chk_state("post_newline");

    // async reset mid-block
    bases(32'h7F7F7F7F);
    rows(pk(10, 20, 30, 40), 2);
    async_reset();
    bases(32'h60606060);
    rows(pk(-100, 100, 255, -256), 4);
    idle(3);
    chk_state("post_reset_blk");

    // random interleaving of base and residual strobes
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(1), $urandom, $urandom_range(1),
           {$urandom, $urandom_range(255)}, ($urandom_range(63) == 0));
      if (i % 25 == 0) chk_state("rand");
    end
    idle(4);
    chk_state("final");
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
